// File: rtl/accumulator_serial.sv
// accumulator_serial: serial multiply-accumulate collector, NP beats of NC signed terms in, one beat of NC sums out.
// Define ACCUMULATOR_SERIAL_BIAS_EN to seed each sample with iData_AM_Bias on its first beat.
module accumulator_serial #(
  parameter  int NP = 4,
  parameter  int NC = 4,
  parameter  int WV = 4,
  localparam int WA = $clog2(NP) + 1 + WV,
  localparam int CW = $clog2(NP) + 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iValid_AM_Prod,
  output logic             oReady_AM_Prod,
  input  logic [NC*WV-1:0] iData_AM_Prod,
  input  logic [NC*WV-1:0] iData_AM_Bias,
  output logic             oValid_BM_Accum,
  input  logic             iReady_BM_Accum,
  output logic [NC*WA-1:0] oData_BM_Accum,
  output logic [CW-1:0]    oCount
);
  logic [NC-1:0][WA-1:0] acc_q, acc_d, sum;
  logic [NC*WA-1:0]      data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  last, in_fire;
  function automatic logic [WA-1:0] ext(input logic [WV-1:0] v);
    return {{(WA-WV){v[WV-1]}}, v};
  endfunction
  assign last           = cnt_q == CW'(NP - 1);
  // only the last beat can be blocked, and only by a result still waiting downstream
  assign oReady_AM_Prod = !last || !valid_q || iReady_BM_Accum;
  assign in_fire        = iValid_AM_Prod && oReady_AM_Prod;
  always_comb begin
    for (int c = 0; c < NC; c++) begin
`ifdef ACCUMULATOR_SERIAL_BIAS_EN
      sum[c] = (cnt_q == '0 ? ext(iData_AM_Bias[c*WV +: WV]) : acc_q[c]) + ext(iData_AM_Prod[c*WV +: WV]);
`else
      sum[c] = (cnt_q == '0 ? {WA{1'b0}} : acc_q[c]) + ext(iData_AM_Prod[c*WV +: WV]);
`endif
    end
  end
`ifndef ACCUMULATOR_SERIAL_BIAS_EN
  logic unused_bias;
  assign unused_bias = ^iData_AM_Bias;
`endif
  always_comb begin
    acc_d   = (in_fire && !last) ? sum : acc_q;
    cnt_d   = in_fire ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    data_d  = (in_fire && last) ? sum : data_q;
    valid_d = (in_fire && last) || (valid_q && !iReady_BM_Accum);
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign oValid_BM_Accum = valid_q;
  assign oData_BM_Accum  = data_q;
  assign oCount          = cnt_q;
endmodule

// File: tb/tb_accumulator_serial.sv
// tb_accumulator_serial: table vectors, corner sequences and random traffic against a queue-based sum model.
module tb_accumulator_serial;
  localparam int NP = 4;
  localparam int NC = 2;
  localparam int WV = 4;
  localparam int WA = $clog2(NP) + 1 + WV;
  localparam int CW = $clog2(NP) + 1;
  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic             iValid = 1'b0;
  logic             iReady = 1'b0;
  logic [NC*WV-1:0] prod = '0;
  logic [NC*WV-1:0] bias = '0;
  logic             oReady, oValid;
  logic [NC*WA-1:0] oData;
  logic [CW-1:0]    oCount;
  accumulator_serial #(.NP(NP), .NC(NC), .WV(WV)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iValid_AM_Prod(iValid), .oReady_AM_Prod(oReady), .iData_AM_Prod(prod), .iData_AM_Bias(bias),
    .oValid_BM_Accum(oValid), .iReady_BM_Accum(iReady), .oData_BM_Accum(oData), .oCount(oCount)
  );
  always #5 iCLK = ~iCLK;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int lane_in(input logic [NC*WV-1:0] d, input int c);
    logic [WV-1:0] t;
    t = d[c*WV +: WV];
    return int'($signed(t));
  endfunction
  function automatic int lane_out(input int c);
    logic [WA-1:0] t;
    t = oData[c*WA +: WA];
    return int'($signed(t));
  endfunction
  // reference model: running per-lane sums and a FIFO of finished sums awaiting transfer
  typedef struct {int v[NC];} res_t;
  res_t expq[$];
  int   part[NC];
  int   mcnt = 0;
  bit   prev_hold = 0;
  logic [NC*WA-1:0] prev_data;
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      mcnt = 0;
      expq.delete();
      prev_hold = 0;
      chk("rst_valid", int'(oValid), 0);
      chk("rst_count", int'(oCount), 0);
      chk("rst_data_zero", int'(oData == '0), 1);
    end else begin
      chk("valid_vs_model", int'(oValid), int'(expq.size() != 0));
      chk("count_vs_model", int'(oCount), mcnt);
      chk("ready_vs_model", int'(oReady), int'(mcnt != NP-1 || expq.size() == 0 || iReady));
      if (prev_hold) begin
        chk("hold_valid", int'(oValid), 1);
        chk("hold_data", int'(oData == prev_data), 1);
      end
      if (oValid && expq.size() != 0)
        for (int c = 0; c < NC; c++) chk("data_vs_model", lane_out(c), expq[0].v[c]);
      prev_hold = oValid && !iReady;
      prev_data = oData;
      if (oValid && iReady && expq.size() != 0) void'(expq.pop_front());
      if (iValid && oReady) begin
        for (int c = 0; c < NC; c++) begin
          int base;
`ifdef ACCUMULATOR_SERIAL_BIAS_EN
          base = lane_in(bias, c);
`else
          base = 0;
`endif
          part[c] = (mcnt == 0 ? base : part[c]) + lane_in(prod, c);
        end
        mcnt++;
        if (mcnt == NP) begin
          res_t r;
          for (int c = 0; c < NC; c++) r.v[c] = part[c];
          expq.push_back(r);
          mcnt = 0;
        end
      end
    end
  end
  bit rnd = 0;
  int stalls = 0;
  task automatic beat(input int a, input int b);
    int k;
    bit ok;
    k = 0;
    iValid = 1'b1;
    prod = {WV'(b), WV'(a)};
    forever begin
      @(negedge iCLK);
      ok = oReady;
      @(posedge iCLK);
      #1;
      if (rnd) iReady = 1'($urandom_range(0, 1));
      if (ok) break;
      stalls++;
      k++;
      if (k > 50) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    iValid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
      if (rnd) iReady = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic expect_out(input string nm, input int e0, input int e1);
    @(negedge iCLK);
    chk({nm, "_valid"}, int'(oValid), 1);
    chk({nm, "_lane0"}, lane_out(0), e0);
    chk({nm, "_lane1"}, lane_out(1), e1);
    @(posedge iCLK);
    #1;
  endtask
  typedef struct {int t0[NP]; int t1[NP]; int e0; int e1;} vec_t;
  vec_t vt[4];
  initial begin
    vt[0].t0 = '{1, 2, 3, 4};     vt[0].t1 = '{-1, -2, -3, -4}; vt[0].e0 = 10;  vt[0].e1 = -10;
    vt[1].t0 = '{-8, -8, -8, -8}; vt[1].t1 = '{7, 7, 7, 7};     vt[1].e0 = -32; vt[1].e1 = 28;
    vt[2].t0 = '{7, -8, 7, -8};   vt[2].t1 = '{-8, 7, 0, 0};    vt[2].e0 = -2;  vt[2].e1 = -1;
    vt[3].t0 = '{0, 0, 0, 5};     vt[3].t1 = '{3, -3, 3, -3};   vt[3].e0 = 5;   vt[3].e1 = 0;
    repeat (2) @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    iReady = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NP; i++) beat(vt[v].t0[i], vt[v].t1[i]);
      @(negedge iCLK);
      chk("tbl_valid", int'(oValid), 1);
      chk("tbl_lane0", lane_out(0), vt[v].e0);
      chk("tbl_lane1", lane_out(1), vt[v].e1);
      if (v == 0) chk("tbl0_lane1_hex", int'(oData[WA +: WA]), 'h76);
      if (v == 1) chk("tbl1_lane0_hex", int'(oData[0 +: WA]), 'h60);
      @(posedge iCLK);
      #1;
    end
    // held result, second sample fills up to its last beat, then release completes both at once
    iReady = 1'b0;
    for (int i = 0; i < NP; i++) beat(1, 2);
    for (int i = 0; i < NP-1; i++) beat(3, -1);
    iValid = 1'b1;
    prod = {WV'(-1), WV'(3)};
    repeat (3) begin
      @(negedge iCLK);
      chk("bp_ready_low", int'(oReady), 0);
      chk("bp_count", int'(oCount), NP-1);
      chk("bp_held_lane0", lane_out(0), 4);
      chk("bp_held_lane1", lane_out(1), 8);
      @(posedge iCLK);
      #1;
    end
    iReady = 1'b1;
    @(negedge iCLK);
    chk("bp_ready_rise", int'(oReady), 1);
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    expect_out("bp_second", 12, -4);
    // back-to-back samples with ready high: no stalls
    stalls = 0;
    for (int i = 0; i < NP; i++) beat(2, -2);
    for (int i = 0; i < NP; i++) beat(-3, 1);
    chk("b2b_stalls", stalls, 0);
    expect_out("b2b_second", -12, 4);
    // async reset mid-sample
    beat(1, 1);
    beat(1, 1);
    #1;
    iRST_N = 1'b0;
    #1;
    chk("async_rst_count", int'(oCount), 0);
    chk("async_rst_valid", int'(oValid), 0);
    chk("async_rst_data", int'(oData == '0), 1);
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    for (int i = 0; i < NP; i++) beat(1, 1);
    @(negedge iCLK);
    chk("post_rst_count", int'(oCount), 0);
    chk("post_rst_lane0", lane_out(0), 4);
    chk("post_rst_lane1", lane_out(1), 4);
    @(posedge iCLK);
    #1;
`ifdef ACCUMULATOR_SERIAL_BIAS_EN
    bias = {WV'(2), WV'(-3)};
    for (int i = 0; i < NP; i++) beat(1, 0);
    expect_out("bias", 1, 2);
    for (int i = 0; i < NP; i++) begin
      bias = (i == 0) ? {WV'(2), WV'(-3)} : NC*WV'($urandom);
      beat(1, 0);
      if (i < NP-1) idle($urandom_range(0, 3));
    end
    expect_out("bias_gaps", 1, 2);
    bias = '0;
`endif
    rnd = 1;
    for (int i = 0; i < 200; i++) begin
      bias = NC*WV'($urandom);
      beat(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      idle($urandom_range(0, 2));
    end
    rnd = 0;
    iReady = 1'b1;
    for (int k = 0; k < 20 && expq.size() != 0; k++) idle(1);
    chk("drain_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/accumulator_serial.md
Name: accumulator_serial

Overview:
- Serial multiply-accumulate collector. It sits directly upstream of the neuron activation stage.
- Consumes NP beats per sample, one beat per parent neuron. Each beat carries NC signed WV-bit weighted terms, one per child.
- Emits one beat of NC signed sums of width WA = $clog2(NP)+1+WV, the exact format the activation stage expects on its Accum input.
- Output is registered, so the next sample accumulates while the previous result waits downstream.

Parameters:
NP, 4, number of parent terms summed per sample (>=1)
NC, 4, number of child lanes processed in parallel (>=1)
WV, 4, signed width of one input term
(derived localparam WA = $clog2(NP)+1+WV, signed output lane width)

Ports:
iCLK  in  1  clock, all state on rising edge
iRST_N  in  1  reset, asynchronous, active-low
iValid_AM_Prod  in  1  input term beat valid
oReady_AM_Prod  out  1  input term beat ready
iData_AM_Prod  in  NC*WV  lane c = bits [c*WV +: WV], two's complement
iData_AM_Bias  in  NC*WV  per-lane bias, sampled only with the optional feature
oValid_BM_Accum  out  1  sum beat valid
iReady_BM_Accum  in  1  sum beat ready
oData_BM_Accum  out  NC*WA  lane c = bits [c*WA +: WA], two's complement sum
oCount  out  $clog2(NP)+1  index of the next beat to be accepted (0..NP-1)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (iRST_N low, applied immediately): acc lanes=0, cnt=0, oValid_BM_Accum=0, oData_BM_Accum=0, oCount=0. Reset mid-sample discards the partial sum and any unconsumed output.
- Input transfer occurs when iValid_AM_Prod & oReady_AM_Prod; output transfer occurs when oValid_BM_Accum & iReady_BM_Accum.
- Each term is sign-extended WV->WA before addition. Arithmetic is modulo 2^WA, but WA guarantees no overflow for up to 2^($clog2(NP)+1) terms.
- On accepted beat with cnt==0: acc[c] <= ext(term[c]) (fresh start, no clear cycle).
- On accepted beat with 0<cnt<NP-1: acc[c] <= acc[c]+ext(term[c]).
- On accepted beat with cnt==NP-1 (the last beat):
  - oData lane c <= sum including this beat (acc[c]+term[c], or ext(term[c]) alone when NP==1);
  - oValid_BM_Accum <= 1;
  - cnt <= 0.
- Any other accepted beat: cnt <= cnt+1.
- Latency: the sum is visible on the cycle after the last beat is accepted.
- oReady_AM_Prod = (cnt != NP-1) | !oValid_BM_Accum | iReady_BM_Accum. Non-last beats are never stalled by the output. The last beat stalls only while an unconsumed result is held.
- Simultaneous output transfer and last-beat completion: the new result replaces the old, oValid_BM_Accum stays 1, and there is no bubble. Sustained throughput is 1 beat/cycle.
- Output transfer without completion: oValid_BM_Accum <= 0. oData_BM_Accum holds its last value.
- oData_BM_Accum and oValid_BM_Accum are stable while valid & !ready (AXI-style; no retraction).
- iData_AM_Prod is ignored when no input transfer occurs. The accumulator and cnt hold while iValid_AM_Prod is low; gaps between beats are allowed.
- oCount = cnt.

Optional Feature:
- Macro ACCUMULATOR_SERIAL_BIAS_EN.
- Defined: on a cnt==0 accepted beat, acc[c] <= ext(bias[c]) + ext(term[c]), with iData_AM_Bias sampled in the same cycle. Every output includes the bias, giving NP+1 terms, which still fit in WA.
- When NP==1 with the macro defined: output = ext(bias)+ext(term).
- Undefined: iData_AM_Bias is unused and the behaviour is exactly as above.

Test Plan:
- NP=4,NC=2,WV=4, macro off. Feed lane0 terms 1,2,3,4 and lane1 terms -1,-2,-3,-4 with ready held 1 -> one output beat, lane0=10, lane1=-10 (7'h76), valid 1 cycle after the 4th beat.
- Saturating extremes: all four lane0 terms -8 -> lane0=-32 (7'h60). All four terms 7 -> 28. Confirms no overflow at WA=7.
- Back-to-back two samples with iReady_BM_Accum held 0:
  - first result is held;
  - beats 0..2 of the second sample are accepted;
  - oReady_AM_Prod=0 on beat 3 until ready rises;
  - the second result then follows with no lost beats.
- iReady_BM_Accum=1 on the same cycle as last-beat completion -> oValid_BM_Accum stays 1 and data updates to the new sum.
- Assert iRST_N low after 2 accepted beats, release, then feed 4 beats of 1 -> output=4 and oCount returns to 0. Outputs read 0 during reset, asynchronously.
- ACCUMULATOR_SERIAL_BIAS_EN defined, bias lane0=-3, terms 1,1,1,1 -> lane0=1. Random valid gaps on the input give the same result.
